// File: rtl/array_prod.sv
// array_prod: sequential fixed-point dot product of two ARRAY_SZ-element
// vectors in signed Q(QN).(QM). One multiply-accumulate per clock into a
// full-precision accumulator, then one arithmetic shift by QM and a
// saturation to BITWIDTH bits when the result is registered.
// A new computation starts only when reset is released.
module array_prod #(
  parameter int ARRAY_SZ = 8,
  parameter int QN       = 6,
  parameter int QM       = 11
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [(QN+QM+1)*ARRAY_SZ-1:0]       weights,
  input  logic [(QN+QM+1)*ARRAY_SZ-1:0]       inputVec,
  output logic                                dataReady,
  output logic [QN+QM:0]                      result
);

  localparam int BITWIDTH = QN + QM + 1;
  localparam int IDX_W    = $clog2(ARRAY_SZ);
  localparam int PROD_W   = 2 * BITWIDTH;
  // log2(ARRAY_SZ) guard bits: a sum of ARRAY_SZ full-precision products
  // can never overflow the accumulator.
  localparam int ACC_W    = PROD_W + IDX_W;
  localparam int UPPER_W  = ACC_W - BITWIDTH + 1;

  // The extra index MSB marks "all elements summed" (ARRAY_SZ is a power of two).
  localparam logic [IDX_W:0] IDX_ONE = {{IDX_W{1'b0}}, 1'b1};

  localparam logic [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [IDX_W:0]             index;
  logic [IDX_W:0]             index_next;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic [BITWIDTH-1:0]        result_next;
  logic                       ready_next;

  logic signed [BITWIDTH-1:0] w_elem;
  logic signed [BITWIDTH-1:0] x_elem;
  logic signed [PROD_W-1:0]   product;
  logic signed [ACC_W-1:0]    scaled;
  logic [UPPER_W-1:0]         scaled_upper;
  logic [BITWIDTH-1:0]        saturated;

  // Select the currently indexed element pair and form the full-precision product.
  always_comb begin
    w_elem  = weights[index[IDX_W-1:0]*BITWIDTH +: BITWIDTH];
    x_elem  = inputVec[index[IDX_W-1:0]*BITWIDTH +: BITWIDTH];
    product = PROD_W'(w_elem) * PROD_W'(x_elem);
  end

  // Scale the finished sum once (floor shift, no rounding) and clamp to BITWIDTH.
  always_comb begin
    scaled       = acc >>> QM;
    scaled_upper = scaled[ACC_W-1:BITWIDTH-1];
    if ((&scaled_upper) || (~|scaled_upper)) begin
      saturated = scaled[BITWIDTH-1:0];
    end else if (scaled[ACC_W-1]) begin
      saturated = SAT_MIN;
    end else begin
      saturated = SAT_MAX;
    end
  end

  // Next-state and datapath control. IDLE is only ever occupied while reset
  // is low, so the first edge after release already sums element 0; that is
  // what gives ARRAY_SZ accumulate edges plus one output edge.
  always_comb begin
    state_next  = state;
    index_next  = index;
    acc_next    = acc;
    result_next = result;
    ready_next  = dataReady;
    case (state)
      IDLE, ACCUM: begin
        if (index[IDX_W]) begin
          state_next  = DONE;
          result_next = saturated;
          ready_next  = 1'b1;
        end else begin
          state_next = ACCUM;
          acc_next   = acc + ACC_W'(product);
          index_next = index + IDX_ONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset low forces IDLE regardless of the clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers; result stays 0 until the completed sum is registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      index     <= '0;
      acc       <= '0;
      result    <= '0;
      dataReady <= 1'b0;
    end else begin
      index     <= index_next;
      acc       <= acc_next;
      result    <= result_next;
      dataReady <= ready_next;
    end
  end

endmodule

// File: tb/tb_array_prod.sv
// tb_array_prod: directed and randomized checks of array_prod against an
// arithmetic reference model (integer sum, floor shift, clamp).
module tb_array_prod;

  localparam int N  = 8;
  localparam int QN = 6;
  localparam int QM = 11;
  localparam int W  = QN + QM + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [W*N-1:0]   weights = '0;
  logic [W*N-1:0]   inputVec = '0;
  logic             dataReady;
  logic [W-1:0]     result;

  int checks   = 0;
  int failures = 0;
  int wv[N];
  int xv[N];

  array_prod #(.ARRAY_SZ(N), .QN(QN), .QM(QM)) dut (
    .clock(clock),
    .reset(reset),
    .weights(weights),
    .inputVec(inputVec),
    .dataReady(dataReady),
    .result(result)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Global time limit so the bench always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: exact integer dot product, floor divide by 2^QM, clamp.
  function automatic logic [W-1:0] modelResult();
    longint sum;
    longint scaled;
    sum = 0;
    for (int i = 0; i < N; i++) sum += longint'(wv[i]) * longint'(xv[i]);
    scaled = sum >>> QM;
    if (scaled > 131071) scaled = 131071;
    else if (scaled < -131072) scaled = -131072;
    return scaled[W-1:0];
  endfunction

  task automatic loadVectors();
    for (int i = 0; i < N; i++) begin
      weights[i*W +: W]  = wv[i][W-1:0];
      inputVec[i*W +: W] = xv[i][W-1:0];
    end
  endtask

  task automatic fillAll(input int wval, input int xval);
    for (int i = 0; i < N; i++) begin
      wv[i] = wval;
      xv[i] = xval;
    end
  endtask

  // Pulse reset, release it mid-cycle and follow the run to dataReady.
  task automatic applyStimulus(input string tag, output logic [W-1:0] finalResult);
    int  edgeCount;
    bit  early;
    loadVectors();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    edgeCount = 0;
    early = 1'b0;
    while (dataReady !== 1'b1 && edgeCount < 20) begin
      if (result !== '0) early = 1'b1;
      @(posedge clock);
      @(negedge clock);
      edgeCount++;
    end
    checkOutput({tag, "_latency"}, 64'(edgeCount), 64'(N + 1));
    checkOutput({tag, "_partial_zero"}, 64'(early), 64'(0));
    checkOutput({tag, "_model"}, 64'(result), 64'(modelResult()));
    finalResult = result;
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] held;
    int           mode;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("reset_ready", 64'(dataReady), 64'(0));
    checkOutput("reset_result", 64'(result), 64'(0));

    // Basic sum: 1.0 * 0.5 over 8 elements = 4.0
    fillAll(2048, 1024);
    applyStimulus("basic", res);
    checkOutput("basic_value", 64'(res), 64'(18'h02000));

    // Hold: inputs scramble in DONE, output stays frozen
    held = modelResult();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) begin
        weights[i*W +: W]  = W'($urandom);
        inputVec[i*W +: W] = W'($urandom);
      end
      @(posedge clock);
      @(negedge clock);
      checkOutput("hold_ready", 64'(dataReady), 64'(1));
      checkOutput("hold_result", 64'(result), 64'(held));
    end

    // Asynchronous reset in DONE, between clock edges
    #2 reset = 1'b0;
    #1;
    checkOutput("done_async_ready", 64'(dataReady), 64'(0));
    checkOutput("done_async_result", 64'(result), 64'(0));
    reset = 1'b1;

    // Sign handling: -1.0 * 2.0
    fillAll(0, 0);
    wv[0] = -2048;
    xv[0] = 4096;
    applyStimulus("sign", res);
    checkOutput("sign_value", 64'(res), 64'(18'h3F000));

    // Saturation, both directions
    fillAll(63488, 63488);
    applyStimulus("sat_pos", res);
    checkOutput("sat_pos_value", 64'(res), 64'(18'h1FFFF));
    fillAll(63488, -63488);
    applyStimulus("sat_neg", res);
    checkOutput("sat_neg_value", 64'(res), 64'(18'h20000));

    // Truncation toward negative infinity
    fillAll(1, 1);
    applyStimulus("trunc_pos", res);
    checkOutput("trunc_pos_value", 64'(res), 64'(18'h00000));
    fillAll(0, 0);
    wv[0] = -1;
    xv[0] = 1;
    applyStimulus("trunc_neg", res);
    checkOutput("trunc_neg_value", 64'(res), 64'(18'h3FFFF));

    // Reset mid-accumulation, then a full restart
    for (int i = 0; i < N; i++) begin
      wv[i] = int'($urandom_range(0, 8191)) - 4096;
      xv[i] = int'($urandom_range(0, 8191)) - 4096;
    end
    loadVectors();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_reset_ready", 64'(dataReady), 64'(0));
    checkOutput("mid_reset_result", 64'(result), 64'(0));
    applyStimulus("mid_restart", res);

    // Reset asserted on the edge where dataReady would rise
    fillAll(2048, 1024);
    loadVectors();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (N) @(posedge clock);
    @(posedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("edge_reset_ready", 64'(dataReady), 64'(0));
    checkOutput("edge_reset_result", 64'(result), 64'(0));
    @(negedge clock);
    checkOutput("edge_reset_hold", 64'(dataReady), 64'(0));
    reset = 1'b1;

    // Randomized vectors across small, medium and full ranges
    for (int t = 0; t < 10; t++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: begin
            wv[i] = int'($urandom_range(0, 4095)) - 2048;
            xv[i] = int'($urandom_range(0, 4095)) - 2048;
          end
          1: begin
            wv[i] = int'($urandom_range(0, 65535)) - 32768;
            xv[i] = int'($urandom_range(0, 65535)) - 32768;
          end
          default: begin
            wv[i] = int'($urandom_range(0, 262143)) - 131072;
            xv[i] = int'($urandom_range(0, 262143)) - 131072;
          end
        endcase
      end
      applyStimulus("random", res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
